// File: rtl/add_slice_sched_if.sv
// rtl/add_slice_sched_if.sv - request/response bundle between requesters, consumer and add_slice_sched
interface add_slice_sched_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/add_slice_sched.sv
// rtl/add_slice_sched.sv - two-requester adder scheduler sharing one SLICE-bit adder, LS slice first
// Define ADDER_SEQ_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module add_slice_sched #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic              clk,
  input logic              rst,
  add_slice_sched_if.slave bus
);
  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state;
  logic [N-1:0][SLICE-1:0]   a_q;
  logic [N-1:0][SLICE-1:0]   b_q;
  logic [N-1:0][SLICE-1:0]   sum_q;
  logic [KW-1:0]             k_q;
  logic                      carry_q;
  logic                      id_q;
  logic                      cout_q;
  logic                      rsp_valid_q;
  logic                      grant;
  logic                      any_valid;
  logic [SLICE:0]            slice_sum;

`ifdef ADDER_SEQ_RR_EN
  logic last_q;

  // Contested cycles go to whoever was not granted last.
  always_comb begin
    if (bus.req0_valid && bus.req1_valid) grant = ~last_q;
    else                                  grant = ~bus.req0_valid;
  end
`else
  always_comb grant = ~bus.req0_valid;
`endif

  assign any_valid      = bus.req0_valid | bus.req1_valid;
  assign bus.req0_ready = (state == IDLE) & any_valid & ~grant;
  assign bus.req1_ready = (state == IDLE) & any_valid & grant;

  // The single shared slice adder; its result is consumed only in RUN.
  assign slice_sum = {1'b0, a_q[k_q]} + {1'b0, b_q[k_q]} + {{SLICE{1'b0}}, carry_q};

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      k_q         <= '0;
      carry_q     <= 1'b0;
      id_q        <= 1'b0;
      cout_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef ADDER_SEQ_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            a_q     <= grant ? bus.req1_a : bus.req0_a;
            b_q     <= grant ? bus.req1_b : bus.req0_b;
            id_q    <= grant;
            k_q     <= '0;
            carry_q <= 1'b0;
            state   <= RUN;
`ifdef ADDER_SEQ_RR_EN
            last_q  <= grant;
`endif
          end
        end
        RUN: begin
          sum_q[k_q] <= slice_sum[SLICE-1:0];
          carry_q    <= slice_sum[SLICE];
          if (k_q == K_LAST) begin
            cout_q      <= slice_sum[SLICE];
            rsp_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
